// File: rtl/ok_buffered_pipe_out_pkg.sv
// Shared host-bus constants and helpers for the ok_* pipe endpoints.
// Address windows are reused by the pipe-in endpoint range check.
`default_nettype none
package ok_buffered_pipe_out_pkg;

  localparam int TI_DATA_W = 16;
  localparam int TI_ADDR_W = 8;

  localparam logic [TI_ADDR_W-1:0] PIPEIN_ADDR_MIN  = 8'h80;
  localparam logic [TI_ADDR_W-1:0] PIPEIN_ADDR_MAX  = 8'h9F;
  localparam logic [TI_ADDR_W-1:0] PIPEOUT_ADDR_MIN = 8'hA0;
  localparam logic [TI_ADDR_W-1:0] PIPEOUT_ADDR_MAX = 8'hBF;

  typedef enum logic [1:0] {
    OCC_EMPTY       = 2'd0,
    OCC_PARTIAL     = 2'd1,
    OCC_BLOCK_READY = 2'd2,
    OCC_FULL        = 2'd3
  } occ_state_e;

  function automatic logic in_pipeout_range(input logic [TI_ADDR_W-1:0] addr);
    return (addr >= PIPEOUT_ADDR_MIN) && (addr <= PIPEOUT_ADDR_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ok_buffered_pipe_out_fifo.sv
// Single-clock first-word-fall-through FIFO; the caller guarantees push/pop legality.
// Storage is not reset, only pointers and occupancy.
`default_nettype none
module ok_pipe_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_head,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally at their DEPTH_LOG2 width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ok_buffered_pipe_out.sv
// Device-to-host output pipe endpoint: user pushes words, host pops them by address.
// Data bus is zero when not addressed so it can be wire-OR'd with other endpoints.
`default_nettype none
module ok_buffered_pipe_out
  import ok_buffered_pipe_out_pkg::*;
#(
  parameter logic [TI_ADDR_W-1:0] EP_ADDR     = 8'hA0,
  parameter int                   DEPTH_LOG2  = 4,
  parameter int                   BLOCK_WORDS = 8
) (
  input  logic                  ti_clock,
  input  logic                  ti_reset_n,
  input  logic [TI_ADDR_W-1:0]  ti_addr,
  input  logic                  ti_read,
  output logic [TI_DATA_W-1:0]  ok_dataout,
  output logic                  ok_ready,
  input  logic                  ep_write,
  input  logic [TI_DATA_W-1:0]  ep_datain,
  output logic                  ep_full,
  output logic [DEPTH_LOG2:0]   ep_count,
  output logic                  ep_read,
  output logic                  err_under,
  output logic                  err_over
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_BLOCK = (DEPTH_LOG2+1)'(BLOCK_WORDS);

  if (!in_pipeout_range(EP_ADDR)) begin : g_bad_ep_addr
    $fatal(1, "ok_buffered_pipe_out: EP_ADDR outside 0xA0..0xBF");
  end
  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 10) begin : g_bad_depth
    $fatal(1, "ok_buffered_pipe_out: DEPTH_LOG2 outside 2..10");
  end
  if (BLOCK_WORDS < 1 || BLOCK_WORDS > DEPTH) begin : g_bad_block
    $fatal(1, "ok_buffered_pipe_out: BLOCK_WORDS outside 1..depth");
  end

  logic                  w_hit;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [TI_DATA_W-1:0]  w_head;
  logic [DEPTH_LOG2:0]   w_count;
  logic                  r_ep_read;
  logic                  r_err_under;
  logic                  r_err_over;

  assign w_hit   = (ti_addr == EP_ADDR);
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_FULL);
  assign w_pop   = ti_read && w_hit && !w_empty;
  // A pop at full frees the slot this same edge, so the push is still accepted.
  assign w_push  = ep_write && (!w_full || w_pop);

  ok_pipe_fifo #(
    .WIDTH      (TI_DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (ti_clock),
    .rst_n   (ti_reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (ep_datain),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge ti_clock or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      r_ep_read   <= 1'b0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
    end else begin
      r_ep_read <= w_pop;
      if (ti_read && w_hit && w_empty)   r_err_under <= 1'b1;
      if (ep_write && w_full && !w_pop)  r_err_over  <= 1'b1;
    end
  end

  assign ok_dataout = (w_hit && !w_empty) ? w_head : '0;
  assign ok_ready   = w_hit && (w_count >= C_BLOCK);
  assign ep_full    = w_full;
  assign ep_count   = w_count;
  assign ep_read    = r_ep_read;
  assign err_under  = r_err_under;
  assign err_over   = r_err_over;

endmodule
`default_nettype wire

// File: tb/tb_ok_buffered_pipe_out.sv
// Bench for ok_buffered_pipe_out: directed table, corner sequences and random traffic
// compared against a queue-based model of the endpoint.
`default_nettype none
module tb_ok_buffered_pipe_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ti_addr;
  logic        ti_read;
  logic [15:0] ok_dataout;
  logic        ok_ready;
  logic        ep_write;
  logic [15:0] ep_datain;
  logic        ep_full;
  logic [4:0]  ep_count;
  logic        ep_read;
  logic        err_under;
  logic        err_over;

  always #5 clk = ~clk;

  ok_buffered_pipe_out #(
    .EP_ADDR     (8'hA0),
    .DEPTH_LOG2  (4),
    .BLOCK_WORDS (8)
  ) dut (
    .ti_clock   (clk),
    .ti_reset_n (rst_n),
    .ti_addr    (ti_addr),
    .ti_read    (ti_read),
    .ok_dataout (ok_dataout),
    .ok_ready   (ok_ready),
    .ep_write   (ep_write),
    .ep_datain  (ep_datain),
    .ep_full    (ep_full),
    .ep_count   (ep_count),
    .ep_read    (ep_read),
    .err_under  (err_under),
    .err_over   (err_over)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [15:0] q[$];
  logic        m_rdp, m_eu, m_eo;

  function automatic logic [25:0] act_vec();
    return {ok_dataout, ok_ready, ep_full, ep_count, ep_read, err_under, err_over};
  endfunction

  function automatic logic [25:0] exp_vec(input logic [7:0] a);
    logic        hit;
    logic [15:0] d;
    hit = (a == 8'hA0);
    d   = (hit && q.size() > 0) ? q[0] : 16'h0000;
    return {d, hit && (q.size() >= 8), q.size() == 16, 5'(q.size()), m_rdp, m_eu, m_eo};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_update(input logic rd, input logic [7:0] a, input logic wr, input logic [15:0] d);
    logic hit, pop, push;
    hit  = (a == 8'hA0);
    pop  = rd && hit && q.size() > 0;
    push = wr && (q.size() < 16 || pop);
    if (rd && hit && q.size() == 0) m_eu = 1'b1;
    if (wr && q.size() == 16 && !pop) m_eo = 1'b1;
    m_rdp = pop;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
  endtask

  task automatic drive(input logic rd, input logic [7:0] a, input logic wr, input logic [15:0] d);
    ti_read = rd; ti_addr = a; ep_write = wr; ep_datain = d;
  endtask

  // Entered at a falling edge; checks pre-edge outputs, then advances one cycle.
  task automatic step(input string name, input logic rd, input logic [7:0] a,
                      input logic wr, input logic [15:0] d);
    drive(rd, a, wr, d);
    #1;
    check(name, act_vec(), exp_vec(a));
    @(posedge clk);
    model_update(rd, a, wr, d);
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdp = 1'b0; m_eu = 1'b0; m_eo = 1'b0;
  endtask

  task automatic reset_mid(input string name);
    #2;
    rst_n = 1'b0;
    ti_addr = 8'hA0;
    #1;
    check(name, act_vec(), 26'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic [7:0]  addr;
    logic        wr;
    logic [15:0] din;
    logic [15:0] e_dout;
    logic [4:0]  e_cnt;
    logic        e_rdp;
    logic        e_eu;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Underflow with simultaneous push, then address isolation, then drain.
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 16'h1234, 16'h0000, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hA0, 1'b0, 16'h0000, 16'h1234, 5'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'hA1, 1'b1, 16'h5678, 16'h0000, 5'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'hA1, 1'b0, 16'h0000, 16'h0000, 5'd2, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hA0, 1'b0, 16'h0000, 16'h1234, 5'd2, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'hA0, 1'b0, 16'h0000, 16'h5678, 5'd1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'hA0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'hA0, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};

    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'hA0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", act_vec(), 26'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rd, tbl[i].addr, tbl[i].wr, tbl[i].din);
      #1;
      check($sformatf("tbl%0d", i), {7'b0, ok_dataout, ep_count, ep_read, err_under},
            {7'b0, tbl[i].e_dout, tbl[i].e_cnt, tbl[i].e_rdp, tbl[i].e_eu});
      check($sformatf("tbl%0d_model", i), act_vec(), exp_vec(tbl[i].addr));
      @(posedge clk);
      model_update(tbl[i].rd, tbl[i].addr, tbl[i].wr, tbl[i].din);
      @(negedge clk);
    end

    // Mid-clock reset must clear sticky errors and occupancy immediately.
    step("pre_rst_push", 1'b0, 8'hA0, 1'b1, 16'hAAAA);
    reset_mid("reset_mid_clock");

    // Block threshold and in-order drain.
    for (int i = 1; i <= 8; i++) step("blk_push", 1'b0, 8'hA0, 1'b1, 16'(i));
    check("blk_ready", {25'b0, ok_ready}, 26'd1);
    for (int i = 0; i < 8; i++) step("blk_read", 1'b1, 8'hA0, 1'b0, 16'h0);
    step("blk_after", 1'b0, 8'hA0, 1'b0, 16'h0);

    // Full: rejected push, then push+pop at full.
    for (int i = 0; i < 16; i++) step("fill", 1'b0, 8'hA0, 1'b1, 16'h0100 + 16'(i));
    step("over_push", 1'b0, 8'hA0, 1'b1, 16'hBEEF);
    check("over_flag", {20'b0, ep_count, err_over}, {20'b0, 5'd16, 1'b1});
    step("full_pushpop", 1'b1, 8'hA0, 1'b1, 16'hCAFE);
    for (int i = 0; i < 15; i++) step("drain", 1'b1, 8'hA0, 1'b0, 16'h0);
    check("cafe_last", {10'b0, ok_dataout}, {10'b0, 16'hCAFE});
    step("drain_last", 1'b1, 8'hA0, 1'b0, 16'h0);
    reset_mid("reset_after_full");

    // Steady stream at occupancy 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b0, 8'hA0, 1'b1, 16'h2000 + 16'(i));
    for (int i = 3; i < 43; i++) step("wrap", 1'b1, 8'hA0, 1'b1, 16'h2000 + 16'(i));
    reset_mid("reset_mid_stream");

    // Random traffic with mixed addresses.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 4))
        0: a = 8'hA1;
        1: a = 8'h80;
        default: a = 8'hA0;
      endcase
      step("rand", 1'($urandom_range(0, 1)), a, ($urandom_range(0, 9) < 6), 16'($urandom));
    end
    step("rand_end", 1'b0, 8'hA0, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
